tick_object_mover: RTL
======================

Name: tick_object_mover

Overview:
- Consumes the level `pulse` from the rate divider. Converts each rising edge into one movement tick.
- On each tick, steps a single object one pixel diagonally across the playfield, bouncing off the borders.
- Drives a req/ack handshake to the downstream pixel-plot stage: erase at the old position, then draw at the new position.
- Sits between the rate divider and the VGA plot controller.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- X_MAX, 159, largest legal x (smallest is 0)
- Y_MAX, 119, largest legal y (smallest is 0)
- X_START, 0, x after reset
- Y_START, 0, y after reset

Ports:
- clock  in  1  system clock, all state on rising edge
- Clear_b  in  1  asynchronous active-low reset
- pulse  in  1  rate divider output (level, high for several cycles per period)
- move_en  in  1  1 = ticks are accepted; 0 = ticks discarded
- plot_ack  in  1  downstream accepted current plot request
- plot_req  out  1  plot request, held until acknowledged
- plot_erase  out  1  1 = plot background colour, 0 = plot object colour
- x_out  out  X_W  plot x coordinate
- y_out  out  Y_W  plot y coordinate
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a tick arrived while one was already pending

Behaviour:

Reset (Clear_b=0, asynchronous):
- State = INIT_DRAW; x=X_START, y=Y_START, dx=+1, dy=+1.
- pulse_d=1, so a high pulse at reset release does not create a tick.
- pending=0, overrun=0, plot_req=0, plot_erase=0.
- x_out=X_START, y_out=Y_START.

Edge detect:
- tick = pulse & ~pulse_d; pulse_d is registered every cycle.
- A tick is valid only when move_en=1 in the same cycle.

State machine (states INIT_DRAW, IDLE, ERASE, STEP, DRAW):
- INIT_DRAW: plot_req=1, plot_erase=0 at the current position. On ack → IDLE.
- IDLE: on a valid tick, or if pending=1 → ERASE next edge. Clear pending if it was consumed.
- ERASE: plot_req=1, plot_erase=1, x_out/y_out = old position. On ack → STEP.
- STEP: one cycle, plot_req=0, position update (below) → DRAW.
- DRAW: plot_req=1, plot_erase=0, x_out/y_out = new position. On ack → IDLE.

Handshake:
- plot_req rises the cycle after entering a request state.
- plot_req, plot_erase, x_out and y_out are stable while plot_req=1.
- Ack is sampled on the rising edge; plot_req is 0 the cycle after ack.
- plot_ack while plot_req=0 is ignored.
- There is no back-to-back request without one req-low cycle (STEP or IDLE) in between.

Position update in STEP (x and y independent):
- If dx=+1 and x==X_MAX: dx←−1, x←x−1.
- Else if dx=−1 and x==0: dx←+1, x←x+1.
- Else x←x+dx.
- Same rules for y with Y_MAX.
- A corner hit flips both directions in the same cycle.
- No wrap-around: x and y never leave [0,MAX].

Ticks while busy:
- A valid tick in any state other than IDLE sets pending=1.
- A valid tick while pending is already 1 sets overrun=1; that tick is dropped (at most one is queued).
- overrun clears only on reset.
- A tick in the same cycle as IDLE is consumed directly and not queued.

move_en:
- move_en=0 discards ticks but does not clear pending or abort a move in progress.

Reset mid-handshake:
- plot_req drops asynchronously.
- Sequence restarts at INIT_DRAW.

Test Plan:
- Reset release with pulse=1; ack one cycle after each req → INIT_DRAW plots (0,0) erase=0, then FSM stays IDLE with no tick.
- Single pulse rising edge, immediate acks → erase (0,0), draw (1,1); next tick → erase (1,1), draw (2,2); busy high throughout each sequence.
- Start at (159,50), dx=+1, dy=+1; one tick → draw (158,51), dx=−1. Corner at (159,119) → (158,118), both directions flipped.
- Hold plot_ack=0 for 20 cycles during ERASE with two pulse edges → req/erase/coords stable; pending=1 then overrun=1; after acks, exactly one extra move executes.
- move_en=0 during three pulse edges → no requests, pending stays 0, position unchanged.
- Assert Clear_b during DRAW with req high → plot_req=0 immediately; after release, INIT_DRAW at (X_START,Y_START).

Source files
------------

// File: rtl/tick_object_mover.sv
// Single-object bouncing mover: turns rising edges of the rate-divider pulse
// into moves, and plots each move as an erase/draw req-ack handshake pair.
module tick_object_mover #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int X_START = 0,
    parameter int Y_START = 0
) (
    input  logic           clock,
    input  logic           Clear_b,
    input  logic           pulse,
    input  logic           move_en,
    input  logic           plot_ack,
    output logic           plot_req,
    output logic           plot_erase,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           busy,
    output logic           overrun
);
    typedef enum logic [2:0] {
        S_INIT_DRAW,
        S_IDLE,
        S_ERASE,
        S_STEP,
        S_DRAW
    } state_t;

    localparam logic [X_W-1:0] X_MAX_V   = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MAX_V   = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_START_V = X_W'(X_START);
    localparam logic [Y_W-1:0] Y_START_V = Y_W'(Y_START);

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d, x_out_q, x_out_d;
    logic [Y_W-1:0] y_q, y_d, y_out_q, y_out_d;
    logic           dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards MAX
    logic           pulse_d_q;
    logic           pending_q, pending_d;
    logic           overrun_q, overrun_d;
    logic           plot_req_q, plot_req_d;
    logic           plot_erase_q, plot_erase_d;

    logic tick;
    logic ack_ok;

    assign tick   = pulse & ~pulse_d_q & move_en;
    assign ack_ok = plot_req_q & plot_ack;

    always_ff @(posedge clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q      <= S_INIT_DRAW;
            x_q          <= X_START_V;
            y_q          <= Y_START_V;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            pulse_d_q    <= 1'b1;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            plot_req_q   <= 1'b0;
            plot_erase_q <= 1'b0;
            x_out_q      <= X_START_V;
            y_out_q      <= Y_START_V;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            pulse_d_q    <= pulse;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            plot_req_q   <= plot_req_d;
            plot_erase_q <= plot_erase_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT_DRAW: if (ack_ok) state_d = S_IDLE;
            S_IDLE:      if (tick || pending_q) state_d = S_ERASE;
            S_ERASE:     if (ack_ok) state_d = S_STEP;
            S_STEP:      state_d = S_DRAW;
            S_DRAW:      if (ack_ok) state_d = S_IDLE;
            default:     state_d = S_INIT_DRAW;
        endcase
    end

    // A tick landing in IDLE while a queued one is being consumed becomes the new queued tick.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == S_IDLE) begin
            pending_d = pending_q & tick;
        end else if (tick) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (state_q == S_STEP) begin
            if (dx_q && x_q == X_MAX_V) begin
                dx_d = 1'b0;
                x_d  = x_q - 1'b1;
            end else if (!dx_q && x_q == '0) begin
                dx_d = 1'b1;
                x_d  = x_q + 1'b1;
            end else begin
                x_d  = dx_q ? x_q + 1'b1 : x_q - 1'b1;
            end
            if (dy_q && y_q == Y_MAX_V) begin
                dy_d = 1'b0;
                y_d  = y_q - 1'b1;
            end else if (!dy_q && y_q == '0) begin
                dy_d = 1'b1;
                y_d  = y_q + 1'b1;
            end else begin
                y_d  = dy_q ? y_q + 1'b1 : y_q - 1'b1;
            end
        end
    end

    // Request fields are captured only while req is low, so they hold for the whole handshake.
    always_comb begin
        plot_req_d   = (state_q == S_INIT_DRAW || state_q == S_ERASE || state_q == S_DRAW) && !ack_ok;
        plot_erase_d = plot_req_q ? plot_erase_q : (state_q == S_ERASE);
        x_out_d      = plot_req_q ? x_out_q : x_q;
        y_out_d      = plot_req_q ? y_out_q : y_q;
    end

    assign plot_req   = plot_req_q;
    assign plot_erase = plot_erase_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
endmodule
